ab_property_monitor: RTL and testbench
======================================

# ab_property_monitor

- Synthesizable, counting checker for the two-bit stimulus stream `{a, b}` driven each clock by the assertion test benches.
- Evaluates the rule "(a==0 and b==1) or (a==1)" on every valid sample across a fixed-length window.
- Counts passes and failures, raises a sticky alarm on a run of consecutive failures, and records where the first failure occurred.
- Sits directly downstream of the stimulus generator; gives on-chip and emulation runs the same verdict as the simulation-only concurrent assertion.

## Interface

Parameters:
- `CNT_W`, 16: width of all counters and index outputs.
- `WIN`, 20: valid samples per evaluation window; range 1 to 2^CNT_W-1.
- `FAIL_LIMIT`, 3: consecutive failures that set `alarm`; range 1 to 2^CNT_W-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; clears all state and opens a window.
- `valid`  in  1  `{a, b}` hold a sample this cycle.
- `a`  in  1  stimulus bit a.
- `b`  in  1  stimulus bit b.
- `busy`  out  1  window open (RUN state).
- `done`  out  1  window complete; results stable.
- `pass_cnt`  out  CNT_W  samples that met the rule.
- `fail_cnt`  out  CNT_W  samples that violated the rule.
- `consec_fail`  out  CNT_W  current run length of consecutive failures.
- `alarm`  out  1  sticky; `consec_fail` reached `FAIL_LIMIT` in this window.
- `first_fail_idx`  out  CNT_W  zero-based window index of the first failing sample.
- `first_fail_vld`  out  1  `first_fail_idx` is meaningful.

## Operation

- Rule: `ok = a | b`, equivalent to (a==0 and b==1) or a==1. A sample fails only when a==0 and b==0.
- FSM states: IDLE, RUN, DONE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE on the valid sample that makes the sample index reach `WIN`.
  - DONE→RUN on `start`.
  - `start` in RUN restarts the window; counters clear and the FSM stays in RUN.
- Actions on `start`, in any state: clear `pass_cnt`, `fail_cnt`, `consec_fail`, the sample index, `alarm` and `first_fail_vld`. Any `valid` in the same cycle is discarded.
- Each valid sample in RUN:
  - On `ok`: increment `pass_cnt` and reset `consec_fail` to 0.
  - Otherwise: increment `fail_cnt` and `consec_fail`.
  - On the first failure of the window: load `first_fail_idx` with the current index and set `first_fail_vld`.
  - Increment the sample index.
- Alarm: set when the updated `consec_fail` equals `FAIL_LIMIT`. It stays set until `start` or reset, even after a later pass.
- Saturation: all counters hold at 2^CNT_W-1; they never wrap.
- `valid` in IDLE or DONE is ignored; counters are frozen.
- `pass_cnt + fail_cnt` equals `WIN` in DONE.

## Timing

- Reset values: all counters 0, `first_fail_idx` 0, `busy`, `done`, `alarm` and `first_fail_vld` all 0, FSM in IDLE.
- All outputs are registered. A sample accepted on edge N is reflected in the outputs after edge N.
- `start` on edge N gives `busy`=1 and cleared outputs after edge N. The first countable sample is at edge N+1.
- `busy` and `done` are mutually exclusive. `done` goes high on the same edge that accepts the WIN-th sample and holds until `start` or reset.
- Reset asserted mid-window returns the block to IDLE immediately, with all outputs at their reset values.
- With `WIN`=1, a single valid sample moves RUN→DONE.

## Configuration

- Macro: `AB_MON_FIRST_FAIL_EN`.
- Defined: the first-failure capture logic is built as described above.
- Undefined: the capture registers are not built. `first_fail_idx` is tied to 0 and `first_fail_vld` to 0. All other behaviour is identical.

## Structure

- Shared package `ab_mon_pkg` holds:
  - the FSM state enum (IDLE, RUN, DONE);
  - the `ab_ok` rule function;
  - the default widths.
- One sub-module, `ab_sat_counter`: a parameterized saturating counter with `clear`, `inc` and reset inputs. It is instantiated for `pass_cnt`, `fail_cnt`, `consec_fail` and the sample index.

## Test plan

- Reset, then `start`, then 20 valid samples of {a,b}=01 → `done`=1, `pass_cnt`=20, `fail_cnt`=0, `alarm`=0, `first_fail_vld`=0.
- Window of {a,b} = 10, 00, 11, 00, 00, 00, then 14 samples of 01 → `fail_cnt`=4, `pass_cnt`=16, `first_fail_idx`=1, `alarm`=1 (set at sample 5) and still 1 at `done`.
- Failures at samples 0–1, then a pass, then two more failures, with `FAIL_LIMIT`=3 → `alarm`=0 and `consec_fail`=2 at the end.
- `start` pulsed at sample 7 of a window with a valid 00 in the same cycle → counters show 0 on the next cycle; that sample is not counted; `done` arrives after 20 further valid samples.
- `rst_n` low mid-window → all outputs 0 and `busy`=0 asynchronously; `valid` samples before the next `start` leave the counts at 0.
- `CNT_W`=4, `WIN`=15, all 15 samples 00 → `fail_cnt`=15, `consec_fail`=15, saturated; built without `AB_MON_FIRST_FAIL_EN` → `first_fail_vld` stays 0.

Source files
------------

// File: rtl/ab_mon_pkg.sv
`default_nettype none
// ============================================================================
// ab_mon_pkg : shared FSM state, pass/fail rule and default widths
// Rev 1.0
// ============================================================================
package ab_mon_pkg;

  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned WIN_DEF        = 20;
  localparam int unsigned FAIL_LIMIT_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ab_state_e;

  // (a==0 && b==1) || a==1 reduces to a|b
  function automatic logic ab_ok(input logic a, input logic b);
    return a | b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ab_sat_counter.sv
`default_nettype none
// ============================================================================
// ab_sat_counter : up-counter with synchronous clear that holds at all-ones
// Rev 1.0
// ============================================================================
module ab_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clear) begin
      q_d = '0;
    end else if (inc && (q_q != C_MAX)) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule
`default_nettype wire

// File: rtl/ab_property_monitor.sv
`default_nettype none
// ============================================================================
// ab_property_monitor : windowed pass/fail counter for the rule a|b with
// consecutive-failure alarm. AB_MON_FIRST_FAIL_EN builds first-failure capture.
// Rev 1.0
// ============================================================================
module ab_property_monitor
  import ab_mon_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned WIN        = WIN_DEF,
  parameter int unsigned FAIL_LIMIT = FAIL_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] consec_fail,
  output logic             alarm,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_vld
);

  localparam logic [CNT_W-1:0] C_WIN   = CNT_W'(WIN);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(FAIL_LIMIT);
  localparam logic [CNT_W-1:0] C_MAX   = {CNT_W{1'b1}};

  ab_state_e        state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] consec_inc;
  logic [CNT_W-1:0] idx_inc;
  logic             ok;
  logic             accept;

  assign ok     = ab_ok(a, b);
  // a start in the same cycle discards the sample
  assign accept = (state_q == ST_RUN) && valid && !start;

  ab_sat_counter #(.W(CNT_W)) u_pass (
    .clk(clk), .rst_n(rst_n), .clear(start), .inc(accept && ok), .q(pass_cnt)
  );
  ab_sat_counter #(.W(CNT_W)) u_fail (
    .clk(clk), .rst_n(rst_n), .clear(start), .inc(accept && !ok), .q(fail_cnt)
  );
  ab_sat_counter #(.W(CNT_W)) u_consec (
    .clk(clk), .rst_n(rst_n), .clear(start || (accept && ok)), .inc(accept && !ok),
    .q(consec_fail)
  );
  ab_sat_counter #(.W(CNT_W)) u_idx (
    .clk(clk), .rst_n(rst_n), .clear(start), .inc(accept), .q(idx_q)
  );

  // Values the counters will hold after this edge, used for the alarm and window end
  assign consec_inc = (consec_fail == C_MAX) ? consec_fail : consec_fail + CNT_W'(1);
  assign idx_inc    = (idx_q == C_MAX) ? idx_q : idx_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    alarm_d = alarm_q;
    if (start) begin
      state_d = ST_RUN;
      alarm_d = 1'b0;
    end else if (accept) begin
      if (!ok && (consec_inc == C_LIMIT)) begin
        alarm_d = 1'b1;
      end
      if (idx_inc == C_WIN) begin
        state_d = ST_DONE;
      end
    end
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign alarm = alarm_q;

`ifdef AB_MON_FIRST_FAIL_EN
  logic [CNT_W-1:0] ff_idx_q, ff_idx_d;
  logic             ff_vld_q, ff_vld_d;

  always_comb begin
    ff_idx_d = ff_idx_q;
    ff_vld_d = ff_vld_q;
    if (start) begin
      ff_idx_d = '0;
      ff_vld_d = 1'b0;
    end else if (accept && !ok && !ff_vld_q) begin
      ff_idx_d = idx_q;
      ff_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_idx_q <= '0;
      ff_vld_q <= 1'b0;
    end else begin
      ff_idx_q <= ff_idx_d;
      ff_vld_q <= ff_vld_d;
    end
  end

  assign first_fail_idx = ff_idx_q;
  assign first_fail_vld = ff_vld_q;
`else
  assign first_fail_idx = '0;
  assign first_fail_vld = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ab_property_monitor.sv
`default_nettype none
// ============================================================================
// tb_ab_property_monitor : scoreboard bench for ab_property_monitor
// Rev 1.0
// ============================================================================
module tb_ab_property_monitor;

  localparam int MAXV  = 65535;
  localparam int WIN   = 20;
  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, valid, a, b;
  logic        busy, done, alarm, ff_vld;
  logic [15:0] pass_cnt, fail_cnt, consec, ff_idx;

  logic        start_s, valid_s, a_s, b_s;
  logic        busy_s, done_s, alarm_s, ff_vld_s;
  logic [3:0]  pass_s, fail_s, consec_s, ff_idx_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ab_property_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid), .a(a), .b(b),
    .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .consec_fail(consec), .alarm(alarm), .first_fail_idx(ff_idx),
    .first_fail_vld(ff_vld)
  );

  ab_property_monitor #(.CNT_W(4), .WIN(15), .FAIL_LIMIT(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .valid(valid_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .pass_cnt(pass_s), .fail_cnt(fail_s),
    .consec_fail(consec_s), .alarm(alarm_s), .first_fail_idx(ff_idx_s),
    .first_fail_vld(ff_vld_s)
  );

  typedef struct {
    logic busy;
    logic done;
    int   pass;
    int   fail;
    int   consec;
    logic alarm;
    int   ffidx;
    logic ffvld;
  } exp_t;

  exp_t sb[$];

  // reference model: 0 idle, 1 run, 2 done
  int   m_state, m_pass, m_fail, m_consec, m_idx, m_ffidx;
  logic m_alarm, m_ffvld;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_pass = 0; m_fail = 0; m_consec = 0; m_idx = 0;
    m_ffidx = 0; m_alarm = 1'b0; m_ffvld = 1'b0;
  endtask

  function automatic int sat(input int v);
    return (v >= MAXV) ? MAXV : v + 1;
  endfunction

  task automatic model_update(input logic s, input logic v, input logic ia, input logic ib);
    if (s) begin
      m_state = 1; m_pass = 0; m_fail = 0; m_consec = 0; m_idx = 0;
      m_alarm = 1'b0; m_ffvld = 1'b0; m_ffidx = 0;
    end else if (m_state == 1 && v) begin
      if (ia || ib) begin
        m_pass   = sat(m_pass);
        m_consec = 0;
      end else begin
        m_fail   = sat(m_fail);
        m_consec = sat(m_consec);
        if (!m_ffvld) begin
          m_ffidx = m_idx;
          m_ffvld = 1'b1;
        end
        if (m_consec == LIMIT) m_alarm = 1'b1;
      end
      m_idx = sat(m_idx);
      if (m_idx == WIN) m_state = 2;
    end
  endtask

  task automatic step(input logic s, input logic v, input logic ia, input logic ib);
    exp_t e;
    @(negedge clk);
    start = s; valid = v; a = ia; b = ib;
    model_update(s, v, ia, ib);
    e.busy = (m_state == 1);
    e.done = (m_state == 2);
    e.pass = m_pass; e.fail = m_fail; e.consec = m_consec; e.alarm = m_alarm;
`ifdef AB_MON_FIRST_FAIL_EN
    e.ffidx = m_ffidx; e.ffvld = m_ffvld;
`else
    e.ffidx = 0; e.ffvld = 1'b0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("pass_cnt", 32'(pass_cnt), e.pass);
    chk("fail_cnt", 32'(fail_cnt), e.fail);
    chk("consec_fail", 32'(consec), e.consec);
    chk("alarm", 32'(alarm), 32'(e.alarm));
    chk("first_fail_idx", 32'(ff_idx), e.ffidx);
    chk("first_fail_vld", 32'(ff_vld), 32'(e.ffvld));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass_cnt), 0);
    chk({tag, "_fail"}, 32'(fail_cnt), 0);
    chk({tag, "_consec"}, 32'(consec), 0);
    chk({tag, "_alarm"}, 32'(alarm), 0);
    chk({tag, "_ffidx"}, 32'(ff_idx), 0);
    chk({tag, "_ffvld"}, 32'(ff_vld), 0);
    chk({tag, "_s_busy"}, 32'(busy_s), 0);
    chk({tag, "_s_fail"}, 32'(fail_s), 0);
  endtask

  initial begin
    logic [1:0] pat2 [6];
    pat2 = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00};
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; a = 1'b0; b = 1'b0;
    start_s = 1'b0; valid_s = 1'b0; a_s = 1'b0; b_s = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // valid in IDLE is ignored
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);

    // all-pass window, then frozen in DONE
    step(1, 0, 0, 0);
    repeat (WIN) step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);

    // alarm and first-fail window
    step(1, 0, 0, 0);
    foreach (pat2[i]) step(0, 1, pat2[i][1], pat2[i][0]);
    repeat (14) step(0, 1, 0, 1);

    // broken failure runs never reach the limit
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 1, 0, 0);

    // restart mid-window with a colliding sample
    step(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 1'(i % 2), 1'b0);
    step(1, 1, 0, 0);
    for (int i = 0; i < WIN; i++) begin
      step(0, 1, 0, 1);
      if (i == 10) step(0, 0, 0, 0);
    end

    // random window
    step(1, 0, 0, 0);
    repeat (30) step(0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));

    // asynchronous reset mid-window
    step(1, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 1, 0, 0);

    // narrow instance: 15 failures reach the all-ones ceiling
    @(negedge clk);
    valid = 1'b0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0; valid_s = 1'b1; a_s = 1'b0; b_s = 1'b0;
    repeat (17) @(negedge clk);
    chk("sat_fail_cnt", 32'(fail_s), 15);
    chk("sat_consec", 32'(consec_s), 15);
    chk("sat_pass_cnt", 32'(pass_s), 0);
    chk("sat_done", 32'(done_s), 1);
    chk("sat_busy", 32'(busy_s), 0);
    chk("sat_alarm", 32'(alarm_s), 1);
`ifdef AB_MON_FIRST_FAIL_EN
    chk("sat_ffvld", 32'(ff_vld_s), 1);
`else
    chk("sat_ffvld", 32'(ff_vld_s), 0);
`endif
    chk("sat_ffidx", 32'(ff_idx_s), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
